// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer for the single-cycle core.
// Fetches over a req/ack handshake, waits for commit, and flags misaligned targets and bus timeouts.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        commit,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic [31:0] fetch_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam int unsigned TW = 8;
    // Last wait count before the fetch is declared dead.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic          mis_q, mis_d;
    logic          err_q, err_d;

    logic npc_aligned;
    assign npc_aligned = (npc[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        mis_d   = mis_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    cnt_d   = cnt_q + 32'd1;
                    to_d    = '0;
                    state_d = S_EXEC;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    to_d = to_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    if (npc_aligned) begin
                        pc_d    = npc;
                        state_d = S_FETCH;
                    end else begin
                        mis_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign imem_req   = (state_q == S_FETCH);
    assign inst_valid = (state_q == S_EXEC);
    assign inst       = inst_q;
    assign fetch_cnt  = cnt_q;
    assign misalign   = mis_q;
    assign bus_err    = err_q;

endmodule
